// File: rtl/ecc_ladder_ctrl.sv
// Montgomery-ladder microcode sequencer for the GF(2^233) datapath.
// Optional abort input is enabled by defining ECC_LADDER_ABORT_EN.
module ecc_ladder_ctrl #(
  parameter int KEY_W    = 233,
  parameter int STEP_CNT = 6,
  parameter int SETTLE   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ECC_LADDER_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             done,
  output logic             zero_key,
  output logic [9:0]       cword,
  output logic             wr_en,
  output logic [1:0]       wr_addr,
  output logic             init_en,
  output logic             final_en,
  output logic [7:0]       bit_idx
);

  // state | meaning
  // IDLE  | waiting for start
  // INIT  | load ladder initial values
  // SCAN  | locate scalar MSB
  // STEP  | drive cword, let datapath settle
  // WB    | write result, destination swapped by key bit
  // NEXT  | advance to next lower key bit
  // FINAL | affine-conversion capture
  // DONE  | completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SCAN, S_STEP, S_WB, S_NEXT, S_FINAL, S_DONE
  } state_t;

  localparam int STEP_W = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CNT - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t            state_q, state_n;
  logic [KEY_W-1:0]  key_q, key_n;
  logic              zero_q, zero_n;
  logic [7:0]        bit_q, bit_n;
  logic [STEP_W-1:0] step_q, step_n;
  logic [3:0]        cnt_q, cnt_n;

  logic [9:0] rom_cword;
  logic [1:0] rom_dst;
  logic [7:0] msb_idx;

  always_comb begin
    rom_cword = 10'h000;
    rom_dst   = 2'd0;
    case (step_q)
      STEP_W'(0): begin rom_cword = 10'h049; rom_dst = 2'd1; end
      STEP_W'(1): begin rom_cword = 10'h0D2; rom_dst = 2'd0; end
      STEP_W'(2): begin rom_cword = 10'h11B; rom_dst = 2'd3; end
      STEP_W'(3): begin rom_cword = 10'h2A4; rom_dst = 2'd2; end
      STEP_W'(4): begin rom_cword = 10'h3ED; rom_dst = 2'd0; end
      STEP_W'(5): begin rom_cword = 10'h000; rom_dst = 2'd1; end
      default:    begin rom_cword = 10'h000; rom_dst = 2'd0; end
    endcase
  end

  always_comb begin
    msb_idx = 8'd0;
    for (int i = 0; i < KEY_W; i++) begin
      if (key_q[i]) msb_idx = 8'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      zero_q  <= 1'b0;
      bit_q   <= 8'd0;
      step_q  <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_n;
      key_q   <= key_n;
      zero_q  <= zero_n;
      bit_q   <= bit_n;
      step_q  <= step_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    key_n    = key_q;
    zero_n   = zero_q;
    bit_n    = bit_q;
    step_n   = step_q;
    cnt_n    = cnt_q;
    cword    = 10'h000;
    wr_en    = 1'b0;
    wr_addr  = 2'd0;
    init_en  = 1'b0;
    final_en = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_n   = key;
          zero_n  = 1'b0;
          bit_n   = 8'd0;
          state_n = S_INIT;
        end
      end
      S_INIT: begin
        init_en = 1'b1;
        state_n = S_SCAN;
      end
      S_SCAN: begin
        if (key_q == '0) begin
          zero_n  = 1'b1;
          state_n = S_DONE;
        end else if (msb_idx == 8'd0) begin
          state_n = S_FINAL;
        end else begin
          bit_n   = msb_idx - 8'd1;
          step_n  = '0;
          cnt_n   = SETTLE_LD;
          state_n = S_STEP;
        end
      end
      S_STEP: begin
        cword = rom_cword;
        if (cnt_q == 4'd0) state_n = S_WB;
        else               cnt_n   = cnt_q - 4'd1;
      end
      S_WB: begin
        cword   = rom_cword;
        wr_en   = 1'b1;
        wr_addr = rom_dst ^ {key_q[bit_q], 1'b0};
        if (step_q != STEP_LAST) begin
          step_n  = step_q + STEP_W'(1);
          cnt_n   = SETTLE_LD;
          state_n = S_STEP;
        end else begin
          state_n = S_NEXT;
        end
      end
      S_NEXT: begin
        // Test before decrementing so bit_idx stops at zero.
        if (bit_q == 8'd0) begin
          state_n = S_FINAL;
        end else begin
          bit_n   = bit_q - 8'd1;
          step_n  = '0;
          cnt_n   = SETTLE_LD;
          state_n = S_STEP;
        end
      end
      S_FINAL: begin
        final_en = 1'b1;
        state_n  = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
`ifdef ECC_LADDER_ABORT_EN
    if (abort && state_q != S_IDLE) begin
      state_n  = S_IDLE;
      wr_en    = 1'b0;
      wr_addr  = 2'd0;
      final_en = 1'b0;
      done     = 1'b0;
    end
`endif
  end

  assign busy     = (state_q != S_IDLE);
  assign zero_key = zero_q;
  assign bit_idx  = bit_q;

endmodule

// File: tb/tb_ecc_ladder_ctrl.sv
// Scoreboard bench for ecc_ladder_ctrl: a ladder-level reference model queues
// expected pulses; a negedge monitor pops and checks each one the DUT emits.
module tb_ecc_ladder_ctrl;
  localparam int KEY_W    = 233;
  localparam int STEP_CNT = 6;
  localparam int SETTLE   = 2;
  localparam int ITER     = STEP_CNT * (SETTLE + 1) + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [KEY_W-1:0] key;
  logic             busy, done, zero_key, wr_en, init_en, final_en;
  logic [9:0]       cword;
  logic [1:0]       wr_addr;
  logic [7:0]       bit_idx;
`ifdef ECC_LADDER_ABORT_EN
  logic             abort;
`endif

  ecc_ladder_ctrl #(.KEY_W(KEY_W), .STEP_CNT(STEP_CNT), .SETTLE(SETTLE)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ECC_LADDER_ABORT_EN
    .abort(abort),
`endif
    .start(start),
    .key(key),
    .busy(busy),
    .done(done),
    .zero_key(zero_key),
    .cword(cword),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .init_en(init_en),
    .final_en(final_en),
    .bit_idx(bit_idx)
  );

  typedef struct {
    int         cyc;
    int         kind;  // 0 init, 1 write, 2 final, 3 done
    logic [9:0] cw;
    logic [1:0] addr;
    logic       zk;
    logic [7:0] bidx;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  logic [9:0] rom_cw  [STEP_CNT] = '{10'h049, 10'h0D2, 10'h11B, 10'h2A4, 10'h3ED, 10'h000};
  logic [1:0] rom_dst [STEP_CNT] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd0, 2'd1};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int kind, input logic [9:0] cw,
                         input logic [1:0] addr, input logic zk, input logic [7:0] bidx);
    ev_t e;
    e.cyc = c; e.kind = kind; e.cw = cw; e.addr = addr; e.zk = zk; e.bidx = bidx;
    exp_q.push_back(e);
  endtask

  // Ladder model: one iteration per key bit below the MSB, STEP_CNT writes each.
  task automatic model(input logic [KEY_W-1:0] k, input int base, output int lat);
    int m = -1;
    int t;
    for (int i = 0; i < KEY_W; i++) if (k[i]) m = i;
    push_ev(base + 1, 0, 10'h0, 2'd0, 1'b0, 8'd0);
    if (m < 0) begin
      push_ev(base + 3, 3, 10'h0, 2'd0, 1'b1, 8'd0);
      lat = 3;
      return;
    end
    t = base + 3;
    for (int b = m - 1; b >= 0; b--) begin
      for (int s = 0; s < STEP_CNT; s++)
        push_ev(t + s * (SETTLE + 1) + SETTLE, 1, rom_cw[s],
                rom_dst[s] ^ {k[b], 1'b0}, 1'b0, 8'(b));
      t += ITER;
    end
    push_ev(t, 2, 10'h0, 2'd0, 1'b0, 8'd0);
    push_ev(t + 1, 3, 10'h0, 2'd0, 1'b0, 8'd0);
    lat = 4 + m * ITER;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      int n;
      int kind;
      ev_t e;
      n = 32'(init_en) + 32'(wr_en) + 32'(final_en) + 32'(done);
      if (n > 1) check("pulse_onehot", n, 1);
      if (!busy && cword !== 10'h0) check("idle_cword", cword, 0);
      if (n >= 1) begin
        kind = init_en ? 0 : wr_en ? 1 : final_en ? 2 : 3;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse actual kind=%0d required none (cycle %0d)", kind, cyc + 1);
        end else begin
          e = exp_q.pop_front();
          if (kind != e.kind || (cyc + 1) != e.cyc) begin
            bad++;
            $display("FAIL pulse actual kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                     kind, cyc + 1, e.kind, e.cyc);
          end
          if (kind == 1) begin
            check("wr_addr", wr_addr, e.addr);
            check("wr_cword", cword, e.cw);
            check("wr_bit_idx", bit_idx, e.bidx);
          end
          if (kind == 3) begin
            check("done_zero_key", zero_key, e.zk);
            check("done_bit_idx", bit_idx, e.bidx);
          end
        end
      end
    end
  end

  task automatic run(input logic [KEY_W-1:0] k, input bit inj, input bit hold);
    int base, off, lat;
    bit fin;
    @(posedge clk); #2;
    start = 1'b1; key = k; base = cyc + 1;
    model(k, base, lat);
    @(posedge clk); #2;
    start = 1'b0; off = 1; fin = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      if (hold && off >= 3 && off <= 5) check("cword_hold", cword, 10'h049);
      if (inj && off == 10) begin start = 1'b1; key = '0; end
      if (inj && off == 11) start = 1'b0;
      if (done) begin
        fin = 1'b1;
        check("latency", off, lat);
        break;
      end
      @(posedge clk); #2;
      off++;
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL timeout actual=no done required=done at +%0d", lat);
    end
    @(posedge clk); #2;
    check("zero_key_held", zero_key, (k == '0));
    check("busy_after", busy, 0);
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_reset();
    int base, lat;
    @(posedge clk); #2;
    start = 1'b1; key = KEY_W'(5); base = cyc + 1;
    model(KEY_W'(5), base, lat);
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_busy", busy, 1);
    check("pre_reset_cword", cword, 10'h049);
    rst_n = 1'b0;
    @(posedge clk); #2;
    check("rst_busy", busy, 0);
    check("rst_cword", cword, 0);
    check("rst_wr_en", wr_en, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (40) @(posedge clk);
    #2;
    check("post_rst_busy", busy, 0);
    check("post_rst_bit_idx", bit_idx, 0);
  endtask

`ifdef ECC_LADDER_ABORT_EN
  task automatic run_abort();
    int base, lat;
    ev_t keep[$];
    @(posedge clk); #2;
    start = 1'b1; key = KEY_W'(2); base = cyc + 1;
    model(KEY_W'(2), base, lat);
    foreach (exp_q[i]) if (exp_q[i].cyc < base + 8) keep.push_back(exp_q[i]);
    exp_q = keep;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    repeat (30) @(posedge clk);
    #2;
    check("abort_queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask
`endif

  initial begin
    logic [255:0]     wide;
    logic [KEY_W-1:0] k;
    rst_n = 1'b0; start = 1'b0; key = '0;
`ifdef ECC_LADDER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_zero_key", zero_key, 0);
    check("reset_cword", cword, 0);
    check("reset_wr", {wr_en, wr_addr}, 0);
    check("reset_init_final", {init_en, final_en}, 0);
    check("reset_bit_idx", bit_idx, 0);
    rst_n = 1'b1;

    run(KEY_W'(0), 1'b0, 1'b0);
    run(KEY_W'(1), 1'b0, 1'b0);
    run(KEY_W'(2), 1'b0, 1'b1);
    run(KEY_W'(3), 1'b0, 1'b0);
    run(KEY_W'(2), 1'b1, 1'b1);
    run_reset();
`ifdef ECC_LADDER_ABORT_EN
    run_abort();
`endif
    for (int r = 0; r < 5; r++) begin
      wide = '0;
      wide[31:0] = 32'($urandom_range(1, 65535));
      k = wide[KEY_W-1:0];
      run(k, 1'b0, 1'b0);
    end
    for (int w = 0; w < 8; w++) wide[w*32 +: 32] = $urandom;
    k = wide[KEY_W-1:0];
    k[KEY_W-1] = 1'b1;
    run(k, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
